// File: rtl/ast_tensor_sequencer_sv.sv
// ast_tensor_sequencer_sv
// Command-driven front end for the systolic tensor system. A single
// dimension command is followed by an element stream: matrix A is pushed,
// then matrix B, the array is started, and the Q x K result is drained
// through a one-entry output register onto a valid/ready stream.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a command; cmd_ready high
//   LOAD_A  | pushing Q*R elements of A (ts_set=0, depth=R, width=Q)
//   LOAD_B  | pushing R*K elements of B (ts_set=1, depth=K, width=R)
//   START   | one-cycle ts_start pulse
//   WAIT    | waiting for ts_done
//   DRAIN   | reading Q*K results into the output register
module ast_tensor_sequencer_sv #(
  parameter  int DATAWIDTH = 14,
  parameter  int SIZE      = 4,
  localparam int DW        = $clog2(SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  // command channel
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DW-1:0]        cmd_q_i,
  input  logic [DW-1:0]        cmd_r_i,
  input  logic [DW-1:0]        cmd_k_i,
  input  logic                 cmd_relu_i,
  output logic                 cmd_err_o,
  // element input stream
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATAWIDTH-1:0] in_data_i,
  // result output stream
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATAWIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  // tensor system side
  output logic [DW-1:0]        ts_depth_o,
  output logic [DW-1:0]        ts_width_o,
  output logic [DATAWIDTH-1:0] ts_data_in_o,
  output logic                 ts_wen_o,
  output logic                 ts_set_o,
  output logic                 ts_relu_o,
  output logic                 ts_start_o,
  output logic                 ts_ren_o,
  input  logic                 ts_done_i,
  input  logic [DATAWIDTH-1:0] ts_data_out_i
);

  localparam int CW = $clog2(SIZE * SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          q_q, q_d;
  logic [DW-1:0]          r_q, r_d;
  logic [DW-1:0]          k_q, k_d;
  logic                   relu_q, relu_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   ov_q, ov_d;
  logic [DATAWIDTH-1:0]   od_q, od_d;
  logic                   ol_q, ol_d;

  logic [CW-1:0]          tc_qr, tc_rk, tc_qk;
  logic                   cmd_bad;
  logic                   out_hs;
  logic                   rd_en;

  // Terminal counts derived from the latched dimensions.
  always_comb begin
    tc_qr = CW'(q_q) * CW'(r_q);
    tc_rk = CW'(r_q) * CW'(k_q);
    tc_qk = CW'(q_q) * CW'(k_q);
  end

  // Command dimensions of zero or beyond the array size are rejected.
  always_comb begin
    cmd_bad = (cmd_q_i == '0) || (cmd_q_i > DW'(SIZE)) ||
              (cmd_r_i == '0) || (cmd_r_i > DW'(SIZE)) ||
              (cmd_k_i == '0) || (cmd_k_i > DW'(SIZE));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath next values and tensor-system controls.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    k_d         = k_q;
    relu_d      = relu_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    ov_d        = ov_q;
    od_d        = od_q;
    ol_d        = ol_q;
    cmd_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    ts_depth_o  = '0;
    ts_width_o  = '0;
    ts_wen_o    = 1'b0;
    ts_set_o    = 1'b0;
    ts_start_o  = 1'b0;
    ts_ren_o    = 1'b0;
    out_hs      = ov_q && out_ready_i;
    rd_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            q_d     = cmd_q_i;
            r_d     = cmd_r_i;
            k_d     = cmd_k_i;
            relu_d  = cmd_relu_i;
            cnt_d   = '0;
            state_d = S_LOAD_A;
          end
        end
      end

      S_LOAD_A: begin
        in_ready_o = 1'b1;
        ts_depth_o = r_q;
        ts_width_o = q_q;
        ts_wen_o   = in_valid_i;
        if (in_valid_i) begin
          if (cnt_q == tc_qr - CW'(1)) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_LOAD_B: begin
        in_ready_o = 1'b1;
        ts_set_o   = 1'b1;
        ts_depth_o = k_q;
        ts_width_o = r_q;
        ts_wen_o   = in_valid_i;
        if (in_valid_i) begin
          if (cnt_q == tc_rk - CW'(1)) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_START: begin
        ts_start_o = 1'b1;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (ts_done_i) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Pop only when the output register is free or emptying this cycle,
        // and only while results remain.
        rd_en    = (cnt_q < tc_qk) && (!ov_q || out_ready_i);
        ts_ren_o = rd_en;
        if (rd_en) begin
          od_d  = ts_data_out_i;
          ov_d  = 1'b1;
          ol_d  = (cnt_q == tc_qk - CW'(1));
          cnt_d = cnt_q + CW'(1);
        end else if (out_hs) begin
          ov_d = 1'b0;
          ol_d = 1'b0;
        end
        if (out_hs && ol_q) begin
          ov_d    = 1'b0;
          ol_d    = 1'b0;
          relu_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Latched command, element counter, error pulse and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      r_q    <= '0;
      k_q    <= '0;
      relu_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      ol_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      r_q    <= r_d;
      k_q    <= k_d;
      relu_q <= relu_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      ol_q   <= ol_d;
    end
  end

  assign cmd_err_o    = err_q;
  assign out_valid_o  = ov_q;
  assign out_data_o   = od_q;
  assign out_last_o   = ol_q;
  assign busy_o       = (state_q != S_IDLE);
  assign ts_relu_o    = relu_q;
  assign ts_data_in_o = in_data_i;

endmodule

// File: tb/tb_ast_tensor_sequencer_sv.sv
// Testbench for ast_tensor_sequencer_sv: a behavioural tensor-system model
// plus a table of directed multiply runs and hand-written corner sequences.
module tb_ast_tensor_sequencer_sv;

  localparam int DATAWIDTH = 14;
  localparam int SIZE      = 4;
  localparam int DW        = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid, cmd_ready_o, cmd_relu, cmd_err_o;
  logic [DW-1:0]        cmd_q, cmd_r, cmd_k;
  logic                 in_valid, in_ready_o;
  logic [DATAWIDTH-1:0] in_data;
  logic                 out_valid_o, out_ready, out_last_o, busy_o;
  logic [DATAWIDTH-1:0] out_data_o;
  logic [DW-1:0]        ts_depth_o, ts_width_o;
  logic [DATAWIDTH-1:0] ts_data_in_o, ts_data_out;
  logic                 ts_wen_o, ts_set_o, ts_relu_o, ts_start_o, ts_ren_o;
  logic                 ts_done;

  always #5 clk = ~clk;

  ast_tensor_sequencer_sv #(.DATAWIDTH(DATAWIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_q_i(cmd_q), .cmd_r_i(cmd_r), .cmd_k_i(cmd_k),
    .cmd_relu_i(cmd_relu), .cmd_err_o(cmd_err_o),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_data_i(in_data),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o),
    .ts_depth_o(ts_depth_o), .ts_width_o(ts_width_o),
    .ts_data_in_o(ts_data_in_o), .ts_wen_o(ts_wen_o), .ts_set_o(ts_set_o),
    .ts_relu_o(ts_relu_o), .ts_start_o(ts_start_o), .ts_ren_o(ts_ren_o),
    .ts_done_i(ts_done), .ts_data_out_i(ts_data_out)
  );

  // Tensor-system model: FIFO load, multiply on start, done after a delay.
  logic [DATAWIDTH-1:0] ma [16];
  logic [DATAWIDTH-1:0] mb [16];
  logic [DATAWIDTH-1:0] mx [16];
  int   wa = 0, wb = 0, mq = 0, mr = 0, mk = 0, dcnt = 0;
  int   na = 0, nb = 0, ns = 0;
  logic [4:0] head = '0;
  logic done_q = 1'b0;
  logic done_seen = 1'b0;
  logic early = 1'b0;

  function automatic logic [DATAWIDTH-1:0] xval(input int idx);
    int acc, i, j;
    acc = 0;
    if (mk == 0 || idx >= mq * mk) return '0;
    i = idx / mk;
    j = idx % mk;
    for (int t = 0; t < mr; t++)
      acc += int'($signed(ma[i*mr+t])) * int'($signed(mb[t*mk+j]));
    if (ts_relu_o && acc < 0) acc = 0;
    return acc[DATAWIDTH-1:0];
  endfunction

  always @(posedge clk) begin
    done_q <= 1'b0;
    if (reset) begin
      wa   <= 0;
      wb   <= 0;
      head <= '0;
      dcnt <= 0;
    end else begin
      if (ts_wen_o) begin
        if (!ts_set_o) begin
          if (wa < 16) ma[wa] <= ts_data_in_o;
          wa <= wa + 1;
          mq <= int'(ts_width_o);
          mr <= int'(ts_depth_o);
          na <= na + 1;
        end else begin
          if (wb < 16) mb[wb] <= ts_data_in_o;
          wb <= wb + 1;
          mk <= int'(ts_depth_o);
          nb <= nb + 1;
        end
      end
      if (ts_start_o) begin
        for (int i = 0; i < 16; i++) mx[i] <= xval(i);
        wa        <= 0;
        wb        <= 0;
        head      <= '0;
        dcnt      <= 3;
        ns        <= ns + 1;
        done_seen <= 1'b0;
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) begin
          done_q    <= 1'b1;
          done_seen <= 1'b1;
        end
      end
      if (ts_ren_o) head <= head + 5'd1;
    end
  end

  assign ts_data_out = mx[head[3:0]];
  assign ts_done     = done_q | (early & ts_start_o);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int q, r, k, relu, bp, gap, early;
    int a [16];
    int b [16];
    int x [16];
  } vec_t;

  vec_t vt [6];

  task automatic run_vec(input int vi);
    vec_t v;
    int qk, qr, nel, idx, cyc, n, na0, nb0, ns0, first_ren, last_hs;
    int pat [4];
    v   = vt[vi];
    pat = '{1, 0, 0, 1};
    qk  = v.q * v.k;
    qr  = v.q * v.r;
    nel = qr + v.r * v.k;
    na0 = na; nb0 = nb; ns0 = ns;
    early = v.early[0];

    @(negedge clk);
    chk("cmd_ready_idle", int'(cmd_ready_o), 1);
    cmd_valid = 1'b1;
    cmd_q     = v.q[DW-1:0];
    cmd_r     = v.r[DW-1:0];
    cmd_k     = v.k[DW-1:0];
    cmd_relu  = v.relu[0];
    @(negedge clk);
    #1;
    chk("cmd_ready_busy", int'(cmd_ready_o), 0);
    chk("busy_load", int'(busy_o), 1);
    chk("ts_relu_load", int'(ts_relu_o), v.relu);
    cmd_valid = 1'b0;

    idx = 0;
    cyc = 0;
    while (idx < nel && cyc < 200) begin
      in_valid = (v.gap != 0 && cyc % 3 == 1) ? 1'b0 : 1'b1;
      in_data  = (idx < qr) ? v.a[idx][DATAWIDTH-1:0] : v.b[idx-qr][DATAWIDTH-1:0];
      #1;
      if (in_valid) begin
        chk("in_ready", int'(in_ready_o), 1);
        chk("wen", int'(ts_wen_o), 1);
        chk("set", int'(ts_set_o), (idx >= qr) ? 1 : 0);
        if (in_ready_o) idx++;
      end else begin
        chk("wen_gap", int'(ts_wen_o), 0);
      end
      cyc++;
      @(negedge clk);
    end
    chk("load_count", idx, nel);
    in_valid = 1'b0;
    #1;
    chk("start_pulse", int'(ts_start_o), 1);
    @(negedge clk);
    #1;
    chk("start_once", int'(ts_start_o), 0);

    n = 0;
    cyc = 0;
    first_ren = -1;
    last_hs = -1;
    while (n < qk && cyc < 300) begin
      out_ready = (v.bp != 0) ? pat[cyc % 4][0] : 1'b1;
      #1;
      if (ts_ren_o) begin
        chk("ren_after_done", int'(done_seen), 1);
        if (first_ren < 0) first_ren = cyc;
      end
      if (out_valid_o && !out_ready) chk("ren_stall", int'(ts_ren_o), 0);
      if (out_valid_o && out_ready) begin
        chk("out_data", int'(out_data_o), v.x[n] & 16'h3FFF);
        chk("out_last", int'(out_last_o), (n == qk - 1) ? 1 : 0);
        n++;
        last_hs = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    chk("drain_count", n, qk);
    out_ready = 1'b1;
    #1;
    chk("busy_done", int'(busy_o), 0);
    chk("out_valid_done", int'(out_valid_o), 0);
    chk("ts_relu_done", int'(ts_relu_o), 0);
    if (v.bp == 0) chk("drain_cycles", last_hs - first_ren, qk);
    chk("a_pushes", na - na0, qr);
    chk("b_pushes", nb - nb0, v.r * v.k);
    chk("starts", ns - ns0, 1);
    early = 1'b0;
  endtask

  task automatic reject(input int q, input int r, input int k);
    int na0;
    na0 = na;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_q     = q[DW-1:0];
    cmd_r     = r[DW-1:0];
    cmd_k     = k[DW-1:0];
    cmd_relu  = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("cmd_err_pulse", int'(cmd_err_o), 1);
    chk("reject_busy", int'(busy_o), 0);
    @(negedge clk);
    #1;
    chk("cmd_err_clear", int'(cmd_err_o), 0);
    chk("reject_ready", int'(cmd_ready_o), 1);
    chk("reject_no_wen", na - na0, 0);
  endtask

  initial begin
    int ns0;
    vt[0] = '{q:2, r:2, k:2, relu:0, bp:0, gap:0, early:0,
              a:'{1,0,0,1, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              b:'{5,6,7,8, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              x:'{5,6,7,8, 0,0,0,0, 0,0,0,0, 0,0,0,0}};
    vt[1] = '{q:1, r:4, k:1, relu:0, bp:0, gap:1, early:0,
              a:'{1,2,3,4, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              b:'{1,1,1,1, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              x:'{10,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}};
    vt[2] = '{q:2, r:2, k:2, relu:0, bp:1, gap:0, early:0,
              a:'{1,2,3,4, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              b:'{5,6,7,8, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              x:'{19,22,43,50, 0,0,0,0, 0,0,0,0, 0,0,0,0}};
    vt[3] = '{q:1, r:1, k:1, relu:1, bp:0, gap:0, early:0,
              a:'{-3,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              b:'{2,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              x:'{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}};
    vt[4] = '{q:1, r:1, k:1, relu:0, bp:0, gap:0, early:0,
              a:'{-3,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              b:'{2,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0},
              x:'{-6,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}};
    vt[5] = '{q:4, r:4, k:4, relu:0, bp:0, gap:1, early:1,
              a:'{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1},
              b:'{1,2,3,4, 5,6,7,8, 9,10,11,12, 13,14,15,16},
              x:'{1,2,3,4, 5,6,7,8, 9,10,11,12, 13,14,15,16}};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_q     = '0;
    cmd_r     = '0;
    cmd_k     = '0;
    cmd_relu  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready_o), 1);
    chk("rst_cmd_err", int'(cmd_err_o), 0);
    chk("rst_in_ready", int'(in_ready_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_out", int'({out_valid_o, out_last_o, out_data_o}), 0);
    chk("rst_ts", int'({ts_wen_o, ts_set_o, ts_relu_o, ts_start_o, ts_ren_o,
                        ts_depth_o, ts_width_o}), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i);

    reject(2, 2, 0);
    reject(5, 2, 2);
    run_vec(0);

    // Reset after three A pushes of a 2x4x2 command.
    ns0 = ns;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_q     = 3'd2;
    cmd_r     = 3'd4;
    cmd_k     = 3'd2;
    cmd_relu  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 14'(i + 1);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_ts", int'({ts_wen_o, ts_set_o, ts_relu_o, ts_start_o, ts_ren_o,
                           ts_depth_o, ts_width_o}), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_ready", int'(cmd_ready_o), 1);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_start", ns - ns0, 0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ast_tensor_sequencer_sv.md
# ast_tensor_sequencer_sv

Command-driven sequencer in front of the tensor system (the A*B=X systolic matrix-multiply block). It accepts a single dimension command, then a valid/ready element stream, and performs these steps in order:
- pushes matrix A, then matrix B, into the tensor system's FIFO load port;
- pulses start and waits for done;
- drains the Q×K result through a one-entry output register onto a valid/ready output stream with a last flag.

It replaces host-side bit-banging of wen/set/depth/width/ren.

## Interface
- DATAWIDTH, 14, element width (must match tensor system)
- SIZE, 4, systolic array dimension; max Q, R, K
- DW = $clog2(SIZE)+1 (derived), dimension field width
- clk  in  1  clock
- reset  in  1  synchronous, active-high; also drives tensor system reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_q, cmd_r, cmd_k  in  DW  dimensions of A (Q×R) and B (R×K)
- cmd_relu  in  1  apply ReLU to results
- cmd_err  out  1  one-cycle pulse when a command is rejected
- in_valid  in  1  element valid
- in_ready  out  1  high in LOAD_A/LOAD_B
- in_data  in  DATAWIDTH  A elements row-major, then B elements row-major
- out_valid  out  1  result element valid
- out_ready  in  1  consumer accepts
- out_data  out  DATAWIDTH  result element, X row-major
- out_last  out  1  marks element Q*K-1
- busy  out  1  state != IDLE
- ts_depth, ts_width  out  DW  tensor system load dimensions
- ts_data_in  out  DATAWIDTH  = in_data
- ts_wen, ts_set, ts_relu, ts_start, ts_ren  out  1  tensor system controls
- ts_done  in  1  tensor system done pulse
- ts_data_out  in  DATAWIDTH  tensor system result head

## Operation
- States: IDLE, LOAD_A, LOAD_B, START, WAIT, DRAIN.
- **IDLE:** cmd_ready=1. A command is accepted when cmd_valid&&cmd_ready.
  - If any of Q, R, K is 0 or >SIZE: pulse cmd_err the next cycle and stay in IDLE.
  - Otherwise latch Q/R/K/relu, clear the element counter, and go to LOAD_A.
- **LOAD_A:**
  - Drives ts_set=0, ts_depth=R, ts_width=Q.
  - ts_wen = in_valid (in_ready=1), so each handshake pushes one element.
  - After push number Q*R-1, clear the counter and go to LOAD_B.
- **LOAD_B:**
  - Drives ts_set=1, ts_depth=K, ts_width=R.
  - Same push rule; after push number R*K-1, go to START.
- **START:** ts_start=1 for exactly one cycle, then WAIT.
- **WAIT:** hold until ts_done=1; the next cycle enters DRAIN.
- **DRAIN:**
  - ts_ren=1 in a cycle iff the output register is empty or is being consumed that cycle (out_valid&&out_ready).
  - In that cycle, ts_data_out is sampled into out_data (the head value before the pop) and out_valid is set.
  - out_last=1 on read number Q*K-1.
  - When the last element is handshaken on the output, return to IDLE.
- ts_relu = latched relu from command acceptance until the return to IDLE.
- Element counter is $clog2(SIZE*SIZE)+1 bits; terminal counts Q*R, R*K, Q*K are computed from the latched dims.
- ts_wen, ts_start and ts_ren are never asserted outside their own states.
- ts_data_in is a straight wire from in_data.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1, cmd_err=0, in_ready=0, busy=0.
  - out_valid=0, out_last=0, out_data=0.
  - All ts_* outputs =0.
- Reset mid-operation (any state): IDLE on the next edge, the partial stream is discarded, and no ts_start is issued.
- Command-to-first-push: the accept edge enters LOAD_A, and the first push can occur in the next cycle.
- in_valid=0 gaps: pushing stalls and the counter holds; there is no timeout.
- Last B push → START → WAIT. ts_start is asserted exactly one cycle after the last push.
- ts_done asserted in the same cycle as START: ignored. Done is only recognised in WAIT.
- ts_done arriving while not in WAIT: ignored.
- First ts_ren occurs in the first DRAIN cycle; out_valid rises the following cycle.
- Full throughput with out_ready held at 1: one element per cycle, so Q*K+1 cycles from DRAIN entry to return to IDLE.
- out_ready=0: out_valid, out_data and out_last hold, and ts_ren=0.
- cmd_valid asserted while busy: not accepted (cmd_ready=0).

## Test plan
- **Identity multiply.** Cmd Q=R=K=2, relu=0; A=[1,0,0,1], B=[5,6,7,8], out_ready=1.
  - Outputs 5,6,7,8; out_last only on 8.
  - busy returns to 0 exactly 1 cycle after the last output handshake.
- **Dot product.** Cmd Q=1, R=4, K=1; A=[1,2,3,4], B=[1,1,1,1].
  - 4 ts_wen with ts_set=0, then 4 with ts_set=1.
  - One ts_start; single output 10 with out_last=1.
- **Backpressure.** 2×2×2 case with out_ready toggled 1,0,0,1,…
  - No ts_ren while out_valid&&!out_ready; all 4 values delivered in order, none duplicated.
- **ReLU.** Q=R=K=1, A=[-3] (two's complement), B=[2], relu=1.
  - ts_relu=1 throughout and output 0.
  - Repeat with relu=0: output -6.
- **Rejection.** Cmds with K=0, then Q=SIZE+1.
  - Each gives a cmd_err pulse, stays in IDLE, and no ts_wen occurs.
  - A following valid cmd is accepted normally.
- **Reset mid-load.** Assert reset after 3 A pushes of a 2×4×2 cmd.
  - All ts_* outputs =0 and IDLE on the next cycle.
  - A fresh 2×2×2 identity run then produces correct results.
